// File: rtl/tictac_pkg.sv
// Shared codes, FSM states and default board geometry for the tic-tac-toe controller.
package tictac_pkg;

  localparam logic [1:0] CellEmpty = 2'b00;
  localparam logic [1:0] MarkX     = 2'b01;
  localparam logic [1:0] MarkO     = 2'b10;

  localparam logic [1:0] WinNone = 2'b00;
  localparam logic [1:0] WinX    = 2'b01;
  localparam logic [1:0] WinO    = 2'b10;
  localparam logic [1:0] WinDraw = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StArmed,
    StSample,
    StCommit,
    StEval,
    StRelease,
    StOver
  } state_e;

  localparam int unsigned DefX0Max = 338;
  localparam int unsigned DefX1Min = 344;
  localparam int unsigned DefX1Max = 679;
  localparam int unsigned DefX2Min = 685;
  localparam int unsigned DefX2Max = 1023;
  localparam int unsigned DefY0Max = 251;
  localparam int unsigned DefY1Min = 259;
  localparam int unsigned DefY1Max = 507;
  localparam int unsigned DefY2Min = 515;
  localparam int unsigned DefY2Max = 767;

endpackage

// File: rtl/board_cell_map.sv
// Maps a pointer position to a row-major board cell index; hit_o is low for gaps and off-board.
module board_cell_map
  import tictac_pkg::*;
#(
  parameter int unsigned X0Max = DefX0Max,
  parameter int unsigned X1Min = DefX1Min,
  parameter int unsigned X1Max = DefX1Max,
  parameter int unsigned X2Min = DefX2Min,
  parameter int unsigned X2Max = DefX2Max,
  parameter int unsigned Y0Max = DefY0Max,
  parameter int unsigned Y1Min = DefY1Min,
  parameter int unsigned Y1Max = DefY1Max,
  parameter int unsigned Y2Min = DefY2Min,
  parameter int unsigned Y2Max = DefY2Max
) (
  input  logic [11:0] xpos_i,
  input  logic [11:0] ypos_i,
  output logic [3:0]  cell_o,
  output logic        hit_o
);

  logic [31:0] x32;
  logic [31:0] y32;
  logic [1:0]  col;
  logic [1:0]  row;
  logic        col_ok;
  logic        row_ok;

  assign x32 = {20'd0, xpos_i};
  assign y32 = {20'd0, ypos_i};

  always_comb begin
    col    = 2'd0;
    col_ok = 1'b0;
    if (x32 <= X0Max) begin
      col    = 2'd0;
      col_ok = 1'b1;
    end else if (x32 >= X1Min && x32 <= X1Max) begin
      col    = 2'd1;
      col_ok = 1'b1;
    end else if (x32 >= X2Min && x32 <= X2Max) begin
      col    = 2'd2;
      col_ok = 1'b1;
    end
  end

  always_comb begin
    row    = 2'd0;
    row_ok = 1'b0;
    if (y32 <= Y0Max) begin
      row    = 2'd0;
      row_ok = 1'b1;
    end else if (y32 >= Y1Min && y32 <= Y1Max) begin
      row    = 2'd1;
      row_ok = 1'b1;
    end else if (y32 >= Y2Min && y32 <= Y2Max) begin
      row    = 2'd2;
      row_ok = 1'b1;
    end
  end

  assign hit_o  = col_ok & row_ok;
  assign cell_o = hit_o ? ({2'b00, row} * 4'd3 + {2'b00, col}) : 4'd0;

endmodule

// File: rtl/board_ctl.sv
// Tic-tac-toe game-state controller: debounced clicks become alternating X/O moves with
// win/draw detection; board, turn and result are registered for the renderer.
module board_ctl
  import tictac_pkg::*;
#(
  parameter int unsigned Debounce = 4,
  parameter int unsigned X0Max    = DefX0Max,
  parameter int unsigned X1Min    = DefX1Min,
  parameter int unsigned X1Max    = DefX1Max,
  parameter int unsigned X2Min    = DefX2Min,
  parameter int unsigned X2Max    = DefX2Max,
  parameter int unsigned Y0Max    = DefY0Max,
  parameter int unsigned Y1Min    = DefY1Min,
  parameter int unsigned Y1Max    = DefY1Max,
  parameter int unsigned Y2Min    = DefY2Min,
  parameter int unsigned Y2Max    = DefY2Max
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic [11:0] xpos_i,
  input  logic [11:0] ypos_i,
  input  logic        mouse_left_i,
  input  logic        start_en_i,
  output logic [17:0] board_state_o,
  output logic        turn_o,
  output logic        move_valid_o,
  output logic [3:0]  move_cell_o,
  output logic        game_over_o,
  output logic [1:0]  winner_o
);

  localparam int unsigned CntW = $clog2(Debounce + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(Debounce - 1);

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [17:0]     board_q, board_d;
  logic            turn_q, turn_d;
  logic            mv_q, mv_d;
  logic [3:0]      cell_q, cell_d;
  logic [3:0]      sel_q, sel_d;
  logic            over_q, over_d;
  logic [1:0]      winner_q, winner_d;

  logic [3:0] map_cell;
  logic       map_hit;
  logic [1:0] mark;
  logic [8:0] is_mark;
  logic [8:0] is_used;
  logic       win;
  logic       full;

  board_cell_map #(
    .X0Max(X0Max), .X1Min(X1Min), .X1Max(X1Max), .X2Min(X2Min), .X2Max(X2Max),
    .Y0Max(Y0Max), .Y1Min(Y1Min), .Y1Max(Y1Max), .Y2Min(Y2Min), .Y2Max(Y2Max)
  ) u_map (
    .xpos_i (xpos_i),
    .ypos_i (ypos_i),
    .cell_o (map_cell),
    .hit_o  (map_hit)
  );

  assign mark = turn_q ? MarkO : MarkX;

  always_comb begin
    is_mark = '0;
    is_used = '0;
    for (int k = 0; k < 9; k++) begin
      is_mark[k] = (board_q[2*k +: 2] == mark);
      is_used[k] = (board_q[2*k +: 2] != CellEmpty);
    end
  end

  assign win = (is_mark[0] & is_mark[1] & is_mark[2]) |
               (is_mark[3] & is_mark[4] & is_mark[5]) |
               (is_mark[6] & is_mark[7] & is_mark[8]) |
               (is_mark[0] & is_mark[3] & is_mark[6]) |
               (is_mark[1] & is_mark[4] & is_mark[7]) |
               (is_mark[2] & is_mark[5] & is_mark[8]) |
               (is_mark[0] & is_mark[4] & is_mark[8]) |
               (is_mark[2] & is_mark[4] & is_mark[6]);
  assign full = &is_used;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    board_d  = board_q;
    turn_d   = turn_q;
    mv_d     = 1'b0;
    cell_d   = cell_q;
    sel_d    = sel_q;
    over_d   = over_q;
    winner_d = winner_q;

    case (state_q)
      StIdle: begin
        if (start_en_i) begin
          state_d  = StArmed;
          cnt_d    = '0;
          board_d  = '0;
          turn_d   = 1'b0;
          over_d   = 1'b0;
          winner_d = WinNone;
        end
      end
      StArmed: begin
        if (!mouse_left_i) begin
          cnt_d = '0;
        end else if (cnt_q >= CntLast) begin
          state_d = StSample;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StSample: begin
        sel_d = map_cell;
        if (map_hit && board_q[{map_cell, 1'b0} +: 2] == CellEmpty) begin
          state_d = StCommit;
        end else begin
          state_d = StRelease;
        end
      end
      StCommit: begin
        board_d[{sel_q, 1'b0} +: 2] = mark;
        mv_d    = 1'b1;
        cell_d  = sel_q;
        state_d = StEval;
      end
      StEval: begin
        if (win) begin
          winner_d = mark;
          over_d   = 1'b1;
          state_d  = StOver;
        end else if (full) begin
          winner_d = WinDraw;
          over_d   = 1'b1;
          state_d  = StOver;
        end else begin
          turn_d  = ~turn_q;
          state_d = StRelease;
        end
      end
      StRelease: begin
        // Mirror of the press debounce: only a stable release re-arms the next move.
        if (mouse_left_i) begin
          cnt_d = '0;
        end else if (cnt_q >= CntLast) begin
          state_d = StArmed;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StOver: begin
        if (!start_en_i) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    // Abandoning a game freezes the visible board and result until the next start.
    if (!start_en_i && state_q != StIdle && state_q != StOver) begin
      state_d  = StIdle;
      cnt_d    = '0;
      board_d  = board_q;
      turn_d   = turn_q;
      mv_d     = 1'b0;
      cell_d   = cell_q;
      over_d   = over_q;
      winner_d = winner_q;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      board_q  <= '0;
      turn_q   <= 1'b0;
      mv_q     <= 1'b0;
      cell_q   <= 4'd0;
      sel_q    <= 4'd0;
      over_q   <= 1'b0;
      winner_q <= WinNone;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      board_q  <= board_d;
      turn_q   <= turn_d;
      mv_q     <= mv_d;
      cell_q   <= cell_d;
      sel_q    <= sel_d;
      over_q   <= over_d;
      winner_q <= winner_d;
    end
  end

  assign board_state_o = board_q;
  assign turn_o        = turn_q;
  assign move_valid_o  = mv_q;
  assign move_cell_o   = cell_q;
  assign game_over_o   = over_q;
  assign winner_o      = winner_q;

endmodule
